// File: rtl/compressed_output_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module      : compressed_output_scheduler_if
// Description : Handshake bundle between the compression stage, the output
//               scheduler and the top-level output port.
//   slave  modport : scheduler side (consumes mask/enc, produces out_*)
//   master modport : environment side (produces mask/enc, consumes out_*)
//   start        frame start pulse
//   mask_*       sparsity-mask word stream (valid/ready)
//   enc_*        packed non-zero encoded word stream (valid/ready)
//   out_*        scheduled output word stream (valid/ready), out_is_mask tag
//   busy, done   frame status
// Revision    : 1.0 - initial release
// ============================================================================
interface compressed_output_scheduler_if #(
    parameter int MEM_BW = 128
);
    logic              start;
    logic [MEM_BW-1:0] mask_in;
    logic              mask_valid;
    logic              mask_ready;
    logic [MEM_BW-1:0] enc_in;
    logic              enc_valid;
    logic              enc_ready;
    logic [MEM_BW-1:0] out_data;
    logic              out_is_mask;
    logic              out_valid;
    logic              out_ready;
    logic              busy;
    logic              done;

    modport slave (
        input  start, mask_in, mask_valid, enc_in, enc_valid, out_ready,
        output mask_ready, enc_ready, out_data, out_is_mask, out_valid, busy, done
    );

    modport master (
        output start, mask_in, mask_valid, enc_in, enc_valid, out_ready,
        input  mask_ready, enc_ready, out_data, out_is_mask, out_valid, busy, done
    );
endinterface
`default_nettype wire

// File: rtl/compressed_output_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : compressed_output_scheduler
// Description : Merges the sparsity-mask stream and the packed encoded-word
//               stream onto one output channel in decoder order: one mask
//               word followed by exactly the encoded words it describes,
//               NB_MASK_WORDS times per frame. Single registered output stage.
//   clk      : clock, rising edge
//   rst_in   : synchronous reset, active-high
//   bus      : slave side of compressed_output_scheduler_if
//              (start, mask_*, enc_*, out_*, busy, done)
// Revision    : 1.0 - initial release
// ============================================================================
module compressed_output_scheduler #(
    parameter int MEM_BW        = 128,
    parameter int DATA_WIDTH    = 8,
    parameter int NB_MASK_WORDS = 1568
) (
    input wire clk,
    input wire rst_in,
    compressed_output_scheduler_if.slave bus
);
    localparam int c_ELEMS   = MEM_BW / DATA_WIDTH;
    localparam int c_POP_W   = $clog2(MEM_BW + 1);
    localparam int c_GRP_MAX = MEM_BW / c_ELEMS;
    localparam int c_LEFT_W  = $clog2(c_GRP_MAX + 1);
    localparam int c_CNT_W   = $clog2(NB_MASK_WORDS + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MASK = 2'd1,
        S_ENC  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [c_CNT_W-1:0]  r_mask_cnt;
    logic [c_LEFT_W-1:0] r_enc_left;
    logic [MEM_BW-1:0]   r_out_data;
    logic                r_out_is_mask;
    logic                r_out_valid;
    logic                r_done;

    logic                w_can_load;
    logic                w_mask_ready;
    logic                w_enc_ready;
    logic                w_mask_acc;
    logic                w_enc_acc;
    logic [c_POP_W-1:0]  w_pop;
    logic [c_LEFT_W-1:0] w_grp;
    logic                w_last_mask;
    logic                w_frame_end;
    logic                w_done_nxt;

    // The output register can take a new word when empty or being drained.
    assign w_can_load   = !r_out_valid || bus.out_ready;
    assign w_mask_ready = (r_state == S_MASK) && w_can_load;
    assign w_enc_ready  = (r_state == S_ENC) && w_can_load;
    assign w_mask_acc   = bus.mask_valid && w_mask_ready;
    assign w_enc_acc    = bus.enc_valid && w_enc_ready;

    always_comb begin
        w_pop = '0;
        for (int i = 0; i < MEM_BW; i++) begin
            w_pop = w_pop + c_POP_W'(bus.mask_in[i]);
        end
    end

    // Number of encoded words holding this mask's non-zeros (ceiling division).
    assign w_grp = c_LEFT_W'((32'(w_pop) + 32'(c_ELEMS) - 32'd1) / 32'(c_ELEMS));

    // r_mask_cnt counts accepted masks; it already includes the current one
    // while in ENC, but not the one being accepted in MASK.
    assign w_last_mask = (r_mask_cnt == c_CNT_W'(NB_MASK_WORDS - 1));
    assign w_frame_end = (r_mask_cnt == c_CNT_W'(NB_MASK_WORDS));

    always_comb begin
        w_state_nxt = r_state;
        w_done_nxt  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_state_nxt = S_MASK;
                end
            end
            S_MASK: begin
                if (w_mask_acc) begin
                    if (w_grp != '0) begin
                        w_state_nxt = S_ENC;
                    end else if (w_last_mask) begin
                        w_state_nxt = S_DONE;
                    end
                end
            end
            S_ENC: begin
                if (w_enc_acc && (r_enc_left == c_LEFT_W'(1))) begin
                    w_state_nxt = w_frame_end ? S_DONE : S_MASK;
                end
            end
            S_DONE: begin
                // Pulse done only once the last word has left the register.
                if (w_can_load) begin
                    w_done_nxt  = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_in) begin
            r_state       <= S_IDLE;
            r_mask_cnt    <= '0;
            r_enc_left    <= '0;
            r_out_data    <= '0;
            r_out_is_mask <= 1'b0;
            r_out_valid   <= 1'b0;
            r_done        <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_done  <= w_done_nxt;

            if (w_mask_acc) begin
                r_out_data    <= bus.mask_in;
                r_out_is_mask <= 1'b1;
                r_out_valid   <= 1'b1;
                r_enc_left    <= w_grp;
            end else if (w_enc_acc) begin
                r_out_data    <= bus.enc_in;
                r_out_is_mask <= 1'b0;
                r_out_valid   <= 1'b1;
                r_enc_left    <= r_enc_left - c_LEFT_W'(1);
            end else if (bus.out_ready) begin
                r_out_valid <= 1'b0;
            end

            if (w_done_nxt || (r_state == S_IDLE)) begin
                r_mask_cnt <= '0;
            end else if (w_mask_acc) begin
                r_mask_cnt <= r_mask_cnt + c_CNT_W'(1);
            end
        end
    end

    assign bus.mask_ready  = w_mask_ready;
    assign bus.enc_ready   = w_enc_ready;
    assign bus.out_data    = r_out_data;
    assign bus.out_is_mask = r_out_is_mask;
    assign bus.out_valid   = r_out_valid;
    assign bus.busy        = (r_state != S_IDLE);
    assign bus.done        = r_done;
endmodule
`default_nettype wire

// File: tb/tb_compressed_output_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_compressed_output_scheduler
// Description : Self-checking bench for compressed_output_scheduler. A small
//               instance (2 masks/frame) runs table vectors and corner cases;
//               a full-size instance runs one randomized 1568-mask frame.
//               Expected words are queued when stimulus is queued and popped
//               on each output handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_compressed_output_scheduler;
    localparam int MEM_BW   = 128;
    localparam int ELEMS    = 16;
    localparam int NB_SMALL = 2;
    localparam int NB_FULL  = 1568;

    typedef logic [MEM_BW-1:0] word_t;
    typedef struct { word_t data; logic is_mask; } exp_t;
    typedef struct { word_t mask; int n_enc; } vec_t;

    logic clk = 1'b0;
    logic rst_in;
    always #5 clk = ~clk;

    compressed_output_scheduler_if #(.MEM_BW(MEM_BW)) if_a ();
    compressed_output_scheduler_if #(.MEM_BW(MEM_BW)) if_b ();

    compressed_output_scheduler #(.MEM_BW(MEM_BW), .DATA_WIDTH(8), .NB_MASK_WORDS(NB_SMALL)) u_dut_small (
        .clk    (clk),
        .rst_in (rst_in),
        .bus    (if_a.slave)
    );

    compressed_output_scheduler #(.MEM_BW(MEM_BW), .DATA_WIDTH(8), .NB_MASK_WORDS(NB_FULL)) u_dut_full (
        .clk    (clk),
        .rst_in (rst_in),
        .bus    (if_b.slave)
    );

    // Shared stimulus, steered to the selected instance.
    logic  sel;
    logic  start, mask_valid, enc_valid, out_ready;
    word_t mask_in, enc_in;

    assign if_a.start      = start && !sel;
    assign if_b.start      = start && sel;
    assign if_a.mask_in    = mask_in;
    assign if_b.mask_in    = mask_in;
    assign if_a.enc_in     = enc_in;
    assign if_b.enc_in     = enc_in;
    assign if_a.mask_valid = mask_valid && !sel;
    assign if_b.mask_valid = mask_valid && sel;
    assign if_a.enc_valid  = enc_valid && !sel;
    assign if_b.enc_valid  = enc_valid && sel;
    assign if_a.out_ready  = out_ready;
    assign if_b.out_ready  = out_ready;

    logic  m_mask_ready, m_enc_ready, m_out_is_mask, m_out_valid, m_busy, m_done;
    word_t m_out_data;
    assign m_mask_ready  = sel ? if_b.mask_ready  : if_a.mask_ready;
    assign m_enc_ready   = sel ? if_b.enc_ready   : if_a.enc_ready;
    assign m_out_data    = sel ? if_b.out_data    : if_a.out_data;
    assign m_out_is_mask = sel ? if_b.out_is_mask : if_a.out_is_mask;
    assign m_out_valid   = sel ? if_b.out_valid   : if_a.out_valid;
    assign m_busy        = sel ? if_b.busy        : if_a.busy;
    assign m_done        = sel ? if_b.done        : if_a.done;

    int vectors     = 0;
    int miscompares = 0;

    word_t mask_q[$];
    word_t enc_q[$];
    exp_t  exp_q[$];

    bit    drv_en     = 1'b0;
    bit    gaps       = 1'b0;
    int    ready_mode = 0;
    int    cyc        = 0;
    int    done_cnt   = 0;
    int    last_hs    = -10;
    int    enc_out_cnt = 0;
    bit    acc_m = 1'b0, acc_e = 1'b0;
    bit    stall_pend = 1'b0;
    word_t stall_data;
    logic  stall_is_mask;

    task automatic check(input string name, input logic [MEM_BW-1:0] act, input logic [MEM_BW-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic word_t rand_word();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic push_mask(input word_t m, input int n);
        word_t w;
        mask_q.push_back(m);
        exp_q.push_back('{data: m, is_mask: 1'b1});
        for (int k = 0; k < n; k++) begin
            w = rand_word();
            enc_q.push_back(w);
            exp_q.push_back('{data: w, is_mask: 1'b0});
        end
    endtask

    // Driver + monitor: inputs change on the falling edge, handshakes are
    // sampled 1 time unit later (they take effect on the next rising edge).
    initial begin
        exp_t e;
        mask_valid = 1'b0; enc_valid = 1'b0; out_ready = 1'b0;
        mask_in = '0; enc_in = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (acc_m) void'(mask_q.pop_front());
            if (acc_e) void'(enc_q.pop_front());
            mask_valid = drv_en && (mask_q.size() > 0) && (!gaps || ($urandom_range(0, 3) != 0));
            mask_in    = (mask_q.size() > 0) ? mask_q[0] : '0;
            enc_valid  = drv_en && (enc_q.size() > 0) && (!gaps || ($urandom_range(0, 3) != 0));
            enc_in     = (enc_q.size() > 0) ? enc_q[0] : '0;
            out_ready  = (ready_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            #1;
            acc_m = mask_valid && m_mask_ready && !rst_in;
            acc_e = enc_valid && m_enc_ready && !rst_in;
            if (!rst_in) begin
                if (stall_pend) begin
                    check("stall_valid", m_out_valid, 1);
                    check("stall_data", m_out_data, stall_data);
                    check("stall_is_mask", m_out_is_mask, stall_is_mask);
                end
                stall_pend    = m_out_valid && !out_ready;
                stall_data    = m_out_data;
                stall_is_mask = m_out_is_mask;
                if (m_mask_ready || m_enc_ready)
                    check("ready_exclusive", m_mask_ready && m_enc_ready, 0);
                if (m_out_valid && out_ready) begin
                    last_hs = cyc;
                    if (exp_q.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL extra_out: got %h is_mask %0b expected no output", m_out_data, m_out_is_mask);
                    end else begin
                        e = exp_q.pop_front();
                        check("out_data", m_out_data, e.data);
                        check("out_is_mask", m_out_is_mask, e.is_mask);
                    end
                    if (!m_out_is_mask) enc_out_cnt++;
                end
                if (m_done) begin
                    done_cnt++;
                    check("done_after_last_hs", cyc, last_hs + 1);
                    check("busy_falls_with_done", m_busy, 0);
                end
            end else begin
                stall_pend = 1'b0;
            end
        end
    end

    task automatic run_frame(input logic sel_v, input bit extra_start, input int budget);
        int d0;
        int n;
        sel = sel_v;
        d0  = done_cnt;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        if (extra_start) begin
            @(negedge clk) start = 1'b1;
            @(negedge clk) start = 1'b0;
        end
        n = 0;
        while ((done_cnt == d0) && (n < budget)) begin
            @(negedge clk);
            #2;
            n++;
        end
        if (done_cnt == d0) begin
            vectors++;
            miscompares++;
            $display("FAIL frame_timeout: got no done after %0d cycles, expected done", budget);
        end
        repeat (2) @(negedge clk);
        #2;
        check("done_once", done_cnt - d0, 1);
        check("exp_drained", exp_q.size(), 0);
        check("idle_after_frame", m_busy, 0);
        exp_q.delete();
    endtask

    vec_t tbl[8];

    initial begin
        int n;
        word_t m;
        tbl[0] = '{mask: {MEM_BW{1'b1}},      n_enc: 8};
        tbl[1] = '{mask: {MEM_BW{1'b1}},      n_enc: 8};
        tbl[2] = '{mask: '0,                  n_enc: 0};
        tbl[3] = '{mask: 128'h1,              n_enc: 1};
        tbl[4] = '{mask: 128'hFFFF,           n_enc: 1};
        tbl[5] = '{mask: 128'h1_FFFF,         n_enc: 2};
        tbl[6] = '{mask: {1'b1, 127'b0},      n_enc: 1};
        tbl[7] = '{mask: {64{2'b01}},         n_enc: 4};

        sel = 1'b0; start = 1'b0; rst_in = 1'b1;
        repeat (3) @(negedge clk);
        #2;
        check("rst_out_valid", if_a.out_valid, 0);
        check("rst_out_is_mask", if_a.out_is_mask, 0);
        check("rst_out_data", if_a.out_data, 0);
        check("rst_done", if_a.done, 0);
        check("rst_busy", if_a.busy, 0);
        check("rst_mask_ready", if_a.mask_ready, 0);
        check("rst_enc_ready", if_a.enc_ready, 0);
        check("rst_full_busy", if_b.busy, 0);
        check("rst_full_out_valid", if_b.out_valid, 0);
        @(negedge clk) rst_in = 1'b0;
        drv_en = 1'b1;

        // Table frames: two masks each, one spare encoded word always offered.
        for (int f = 0; f < 4; f++) begin
            push_mask(tbl[2*f].mask, tbl[2*f].n_enc);
            push_mask(tbl[2*f+1].mask, tbl[2*f+1].n_enc);
            enc_q.push_back(rand_word());
            run_frame(1'b0, (f == 1), 300);
            check("spare_enc_not_taken", enc_q.size(), 1);
            enc_q.delete();
        end

        // Reset in the middle of an encoded group.
        enc_out_cnt = 0;
        push_mask({MEM_BW{1'b1}}, 8);
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        n = 0;
        while ((enc_out_cnt < 3) && (n < 100)) begin
            @(negedge clk);
            #2;
            n++;
        end
        check("enc_words_before_rst", enc_out_cnt, 3);
        rst_in = 1'b1;
        drv_en = 1'b0;
        @(negedge clk) rst_in = 1'b0;
        #2;
        check("rst_mid_out_valid", m_out_valid, 0);
        check("rst_mid_busy", m_busy, 0);
        mask_q.delete(); enc_q.delete(); exp_q.delete();
        drv_en = 1'b1;
        push_mask(tbl[0].mask, tbl[0].n_enc);
        push_mask(tbl[7].mask, tbl[7].n_enc);
        run_frame(1'b0, 1'b0, 300);

        // start and reset together: reset wins.
        @(negedge clk) begin start = 1'b1; rst_in = 1'b1; end
        @(negedge clk) begin start = 1'b0; rst_in = 1'b0; end
        #2;
        check("start_rst_busy", m_busy, 0);
        check("start_rst_out_valid", m_out_valid, 0);

        // Full frame, random stalls on both sides.
        ready_mode = 1;
        gaps       = 1'b1;
        for (int i = 0; i < NB_FULL; i++) begin
            case ($urandom_range(0, 3))
                0:       m = '0;
                1:       m = {MEM_BW{1'b1}};
                2:       m = rand_word();
                default: m = rand_word() & rand_word() & rand_word();
            endcase
            push_mask(m, ($countones(m) + ELEMS - 1) / ELEMS);
        end
        run_frame(1'b1, 1'b0, 60000);
        check("full_mask_q_empty", mask_q.size(), 0);
        check("full_enc_q_empty", enc_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
`default_nettype wire
